// File: rtl/cpu_pipe_ctrl_pkg.sv
// cpu_pkg: shared types and defaults for the KH32 pipeline sequencer.
// Holds the state encoding, stage-control bundle and parameter defaults.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_RUN      = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4,
    ST_STEP     = 3'd5
  } state_e;

  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned MEM_TIMEOUT_DEF  = 255;
  localparam int unsigned CNT_W_DEF        = 16;

  localparam int unsigned WCNT_W = 16;
  localparam int unsigned FCNT_W = 3;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic bubble;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctl_t CTL_IDLE  = '{1'b0, 1'b0, 1'b0, 1'b1};
  localparam stage_ctl_t CTL_RUN   = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctl_t CTL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/cpu_pipe_ctrl_if.sv
// cpu_pipe_ctrl_if: EX-side flags in, stage enables and status out.
// master = EX/debug side, slave = the sequencer.
interface cpu_pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             jump_flag;
  logic             mem_access;
  logic             dmem_ack;
  logic             halt_req;
  logic             step_req;
  logic             clr_err;
  logic             if_en;
  logic             id_en;
  logic             ex_en;
  logic             bubble;
  logic [2:0]       state_o;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output jump_flag, mem_access, dmem_ack,
    output halt_req, step_req, clr_err,
    input  if_en, id_en, ex_en, bubble,
    input  state_o, mem_timeout_err, flush_cnt
  );

  modport slave (
    input  jump_flag, mem_access, dmem_ack,
    input  halt_req, step_req, clr_err,
    output if_en, id_en, ex_en, bubble,
    output state_o, mem_timeout_err, flush_cnt
  );
endinterface

// File: rtl/cpu_sat_counter.sv
// cpu_sat_counter: W-bit incrementer that sticks at all-ones.
// Ports: clk, rst (async, active-low), en_i, cnt_o.
module cpu_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_pipe_ctrl.sv
// cpu_pipe_ctrl: IF/ID/EX enable and ID bubble sequencer (flush/mem/debug).
// Ports: clk, rst (async, active-low), bus (slave side of cpu_pipe_ctrl_if).
module cpu_pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  cpu_pipe_ctrl_if.slave bus
);

  localparam logic [FCNT_W-1:0] FC_LOAD =
    FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] TO_LIM =
    WCNT_W'(MEM_TIMEOUT);

  state_e              state_q;
  state_e              state_d;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [WCNT_W-1:0]   wcnt_d;
  logic [FCNT_W-1:0]   fcnt_q;
  logic [FCNT_W-1:0]   fcnt_d;
  logic                from_step_q;
  logic                from_step_d;
  logic                err_q;
  logic                err_d;

  logic                src_step;
  state_e              res_st;
  state_e              iss_st;
  stage_ctl_t          iss_ctl;
  stage_ctl_t          ctl;
  logic                set_err;
  logic                cnt_en;

  // Issue path shared by RUN/STEP and the MEM_WAIT ack cycle.
  // src_step picks the resume rule: STEP origin always returns to HALT.
  always_comb begin
    src_step = from_step_q;
    if (state_q == ST_RUN)  src_step = 1'b0;
    if (state_q == ST_STEP) src_step = 1'b1;
    res_st = (src_step || bus.halt_req || err_q) ? ST_HALT : ST_RUN;
    iss_ctl = bus.jump_flag ? CTL_FLUSH : CTL_RUN;
    iss_st  = res_st;
    if (bus.jump_flag && (FLUSH_CYCLES > 1)) iss_st = ST_FLUSH;
  end

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    fcnt_d      = fcnt_q;
    from_step_d = from_step_q;
    set_err     = 1'b0;
    cnt_en      = 1'b0;
    ctl         = CTL_STALL;
    unique case (state_q)
      ST_START: begin
        ctl     = CTL_IDLE;
        state_d = ST_RUN;
      end
      ST_RUN, ST_STEP: begin
        from_step_d = src_step;
        if (bus.mem_access && !bus.dmem_ack) begin
          state_d = ST_MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          ctl     = iss_ctl;
          state_d = iss_st;
          fcnt_d  = FC_LOAD;
          cnt_en  = bus.jump_flag;
        end
      end
      ST_FLUSH: begin
        ctl    = CTL_FLUSH;
        fcnt_d = fcnt_q - 1'b1;
        if (fcnt_q <= FCNT_W'(1)) state_d = res_st;
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack) begin
          ctl     = iss_ctl;
          state_d = iss_st;
          fcnt_d  = FC_LOAD;
          cnt_en  = bus.jump_flag;
        end else if (wcnt_q >= TO_LIM) begin
          set_err = 1'b1;
          state_d = ST_HALT;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (bus.step_req)                   state_d = ST_STEP;
        else if (!bus.halt_req && !err_q)   state_d = ST_RUN;
      end
      default: state_d = ST_START;
    endcase
  end

  // A timeout in the same cycle as clr_err leaves the flag set.
  always_comb begin
    err_d = err_q;
    if (bus.clr_err) err_d = 1'b0;
    if (set_err)     err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_START;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      from_step_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      from_step_q <= from_step_d;
      err_q       <= err_d;
    end
  end

  cpu_sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cnt_en),
    .cnt_o (bus.flush_cnt)
  );

  assign bus.if_en           = ctl.if_en;
  assign bus.id_en           = ctl.id_en;
  assign bus.ex_en           = ctl.ex_en;
  assign bus.bubble          = ctl.bubble;
  assign bus.state_o         = state_q;
  assign bus.mem_timeout_err = err_q;

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// tb_cpu_pipe_ctrl: two sequencer configs vs. a behavioural model.
// Directed test-plan sequences followed by randomized traffic.
module tb_cpu_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_pipe_ctrl_if #(.CNT_W(4))  ba();
  cpu_pipe_ctrl_if #(.CNT_W(16)) bb();

  cpu_pipe_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (5),
    .CNT_W        (4)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  cpu_pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .MEM_TIMEOUT  (7),
    .CNT_W        (16)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  typedef struct {
    int fc;
    int to;
    int cmax;
  } prm_t;

  // Abstract view: pipeline "mode" flags plus remaining-work counts.
  typedef struct {
    bit started;
    bit halted;
    bit stepping;
    bit waiting;
    bit w_step;
    bit f_step;
    bit err;
    int wait_n;
    int flush_left;
    int jumps;
  } mdl_t;

  typedef struct {
    bit en;
    bit bub;
    int st;
  } exp_t;

  typedef struct {
    bit j, m, a, h, s, c;
  } in_t;

  int   nchk = 0;
  int   nerr = 0;
  prm_t pa = '{fc: 2, to: 5, cmax: 15};
  prm_t pb = '{fc: 3, to: 7, cmax: 65535};
  mdl_t ma;
  mdl_t mb;

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t z = '{default: 0};
    return z;
  endfunction

  function automatic in_t mk(bit j, bit m, bit a, bit h, bit s, bit c);
    in_t i;
    i.j = j; i.m = m; i.a = a; i.h = h; i.s = s; i.c = c;
    return i;
  endfunction

  function automatic mdl_t step_m(input prm_t p, input mdl_t m,
                                  input in_t i, output exp_t e);
    mdl_t n = m;
    bit issue = 0;
    bit fs = 0;
    bit res = 0;
    bit rfs = 0;
    bit set = 0;
    e.en = 0; e.bub = 0; e.st = 0;
    if (!m.started) begin
      e.bub = 1;
      n.started = 1;
    end else if (m.halted) begin
      e.st = 4;
      if (i.s) begin
        n.halted = 0;
        n.stepping = 1;
      end else if (!i.h && !m.err) begin
        n.halted = 0;
      end
    end else if (m.flush_left > 0) begin
      e.st = 2; e.en = 1; e.bub = 1;
      n.flush_left = m.flush_left - 1;
      if (n.flush_left == 0) begin res = 1; rfs = m.f_step; end
    end else if (m.waiting) begin
      e.st = 3;
      if (i.a) begin
        n.waiting = 0; issue = 1; fs = m.w_step;
      end else if (m.wait_n >= p.to) begin
        set = 1; n.waiting = 0; n.halted = 1;
      end else begin
        n.wait_n = m.wait_n + 1;
      end
    end else begin
      e.st = m.stepping ? 5 : 1;
      if (i.m && !i.a) begin
        n.waiting = 1; n.wait_n = 1;
        n.w_step = m.stepping; n.stepping = 0;
      end else begin
        issue = 1; fs = m.stepping;
      end
    end
    if (issue) begin
      e.en = 1;
      n.stepping = 0;
      if (i.j) begin
        e.bub = 1;
        if (m.jumps < p.cmax) n.jumps = m.jumps + 1;
        if (p.fc > 1) begin
          n.flush_left = p.fc - 1;
          n.f_step = fs;
        end else begin
          res = 1; rfs = fs;
        end
      end else begin
        res = 1; rfs = fs;
      end
    end
    if (res) begin
      n.stepping = 0;
      n.halted = rfs || i.h || m.err;
    end
    n.err = set ? 1'b1 : (i.c ? 1'b0 : m.err);
    return n;
  endfunction

  task automatic check_all(input exp_t ea, input mdl_t oa,
                           input exp_t eb, input mdl_t ob);
    chk("a.if_en",  32'(ba.if_en),  32'(ea.en));
    chk("a.id_en",  32'(ba.id_en),  32'(ea.en));
    chk("a.ex_en",  32'(ba.ex_en),  32'(ea.en));
    chk("a.bubble", 32'(ba.bubble), 32'(ea.bub));
    chk("a.state",  32'(ba.state_o), 32'(ea.st));
    chk("a.err",    32'(ba.mem_timeout_err), 32'(oa.err));
    chk("a.fcnt",   32'(ba.flush_cnt), 32'(oa.jumps));
    chk("b.if_en",  32'(bb.if_en),  32'(eb.en));
    chk("b.id_en",  32'(bb.id_en),  32'(eb.en));
    chk("b.ex_en",  32'(bb.ex_en),  32'(eb.en));
    chk("b.bubble", 32'(bb.bubble), 32'(eb.bub));
    chk("b.state",  32'(bb.state_o), 32'(eb.st));
    chk("b.err",    32'(bb.mem_timeout_err), 32'(ob.err));
    chk("b.fcnt",   32'(bb.flush_cnt), 32'(ob.jumps));
  endtask

  task automatic drive(input in_t i);
    ba.jump_flag = i.j; bb.jump_flag = i.j;
    ba.mem_access = i.m; bb.mem_access = i.m;
    ba.dmem_ack = i.a; bb.dmem_ack = i.a;
    ba.halt_req = i.h; bb.halt_req = i.h;
    ba.step_req = i.s; bb.step_req = i.s;
    ba.clr_err = i.c; bb.clr_err = i.c;
  endtask

  task automatic cyc(input in_t i);
    exp_t ea, eb;
    mdl_t na, nb;
    drive(i);
    @(negedge clk);
    na = step_m(pa, ma, i, ea);
    nb = step_m(pb, mb, i, eb);
    check_all(ea, ma, eb, mb);
    ma = na;
    mb = nb;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_n(input in_t i, input int n);
    for (int k = 0; k < n; k++) cyc(i);
  endtask

  task automatic reset_check();
    exp_t ea, eb;
    mdl_t ta, tb;
    ma = mreset();
    mb = mreset();
    ta = step_m(pa, ma, mk(0, 0, 0, 0, 0, 0), ea);
    tb = step_m(pb, mb, mk(0, 0, 0, 0, 0, 0), eb);
    check_all(ea, ma, eb, mb);
  endtask

  initial begin
    in_t idle;
    in_t r;
    bit  hold;
    int  ackw;
    idle = mk(0, 0, 0, 0, 0, 0);
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    rst = 1'b1;

    cyc_n(idle, 3);
    cyc(mk(1, 0, 0, 0, 0, 0));
    cyc_n(idle, 4);
    cyc_n(mk(0, 1, 0, 0, 0, 0), 3);
    cyc(mk(0, 1, 1, 0, 0, 0));
    cyc_n(idle, 2);
    cyc_n(mk(0, 1, 0, 0, 0, 0), 9);
    cyc(mk(0, 0, 1, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 1));
    cyc_n(idle, 3);
    cyc_n(mk(0, 0, 0, 1, 0, 0), 3);
    cyc(mk(0, 0, 0, 1, 1, 0));
    cyc_n(mk(0, 0, 0, 1, 0, 0), 2);
    cyc(mk(0, 0, 0, 1, 1, 0));
    cyc(mk(1, 0, 0, 1, 0, 0));
    cyc_n(mk(0, 0, 0, 1, 0, 0), 4);
    cyc(mk(1, 0, 0, 1, 0, 0));
    cyc_n(mk(0, 0, 0, 1, 0, 0), 3);
    cyc_n(idle, 3);
    for (int k = 0; k < 20; k++) begin
      cyc(mk(1, 0, 0, 0, 0, 0));
      cyc_n(idle, 3);
    end

    hold = 0;
    ackw = 3;
    for (int k = 0; k < 4000; k++) begin
      if (k % 400 == 0) ackw = $urandom_range(0, 6);
      if ($urandom_range(0, 39) == 0) hold = ~hold;
      r.j = ($urandom_range(0, 5) == 0);
      r.m = ($urandom_range(0, 3) == 0);
      r.a = ($urandom_range(0, 7) < ackw);
      r.h = hold;
      r.s = ($urandom_range(0, 7) == 0);
      r.c = ($urandom_range(0, 15) == 0);
      cyc(r);
    end

    cyc_n(idle, 4);
    cyc(mk(0, 0, 0, 0, 0, 1));
    cyc_n(idle, 12);
    cyc(mk(1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    reset_check();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc_n(idle, 3);
    cyc(mk(1, 0, 0, 0, 0, 0));
    cyc_n(idle, 4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
